int_arbiter: RTL and testbench

Round-robin interrupt arbiter sitting between external interrupt sources and the core-local interrupt controller. It collects up to NUM_SRC interrupt lines (level or rising-edge per source), masks them, selects one winner, and drives the core's `int_flag` input until the core accepts. It then holds the source in service until software writes a completion. Software reaches it through the peripheral register bus (enable, mode, pending, claim/complete).

---
 rtl/int_arbiter.sv | 174 +++++++++++++++++
 tb/tb_int_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Round-robin interrupt arbiter: collects level/edge sources, picks one winner,
// raises int_flag_o until the controller acks, then holds it until software completes.
module int_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    input  logic               int_ack_i,
    output logic [7:0]         int_flag_o,
    output logic [ID_W-1:0]    irq_id_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ASSERT  = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_MODE    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] mode_reg;
    logic [NUM_SRC-1:0] src_d_reg;
    logic [NUM_SRC-1:0] edge_pend_reg, edge_pend_next;
    logic [ID_W-1:0]    rr_reg, rr_next;
    logic [ID_W-1:0]    winner_reg, winner_next;

    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] win_mask;
    logic [NUM_SRC-1:0] in_service_mask;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] elig_rot;
    logic [NUM_SRC-1:0] unused_rot_hi;
    logic               found;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    win_id;
    logic               win_enabled;
    logic               win_level_low;
    logic               drop;
    logic               claim;
    logic               complete;
    logic               wr_enable;
    logic               wr_mode;
    logic               unused_bits;

    // (base + offs) mod NUM_SRC, valid for base, offs < NUM_SRC
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offs);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W+1)'(offs);
        if (sum >= (ID_W+1)'(NUM_SRC)) begin
            sum = sum - (ID_W+1)'(NUM_SRC);
        end
        return sum[ID_W-1:0];
    endfunction

    assign src_edge = src_i & ~src_d_reg;
    assign win_id   = winner_reg + ID_W'(1);

    assign claim    = (state_reg == ASSERT) && int_ack_i && !drop;
    assign complete = (state_reg == SERVICE) && we_i && (addr_i[3:2] == REG_CLAIM)
                      && (data_i[ID_W-1:0] == win_id);

    assign wr_enable = we_i && (addr_i[3:2] == REG_ENABLE);
    assign wr_mode   = we_i && (addr_i[3:2] == REG_MODE);

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign win_mask[gi] = (winner_reg == ID_W'(gi));
            // Level sources mirror the registered line; edge sources latch until claimed.
            assign pending[gi] = mode_reg[gi] ? edge_pend_reg[gi] : src_d_reg[gi];
            assign edge_pend_next[gi] = mode_reg[gi]
                                        & (src_edge[gi] | (edge_pend_reg[gi] & ~(claim & win_mask[gi])));
        end
    endgenerate

    assign in_service_mask = (state_reg == SERVICE) ? win_mask : '0;
    assign eligible        = pending & enable_reg & ~in_service_mask;

    assign win_enabled   = |(enable_reg & win_mask);
    assign win_level_low = |(win_mask & ~mode_reg & ~src_d_reg);
    assign drop          = !win_enabled || win_level_low;

    // Rotate so that bit 0 is the source at the round-robin pointer.
    assign {unused_rot_hi, elig_rot} = {eligible, eligible} >> rr_reg;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && elig_rot[k]) begin
                found = 1'b1;
                sel   = wrap_idx(rr_reg, k);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        rr_next     = rr_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next  = ASSERT;
                    winner_next = sel;
                end
            end
            ASSERT: begin
                if (drop) begin
                    state_next = IDLE;
                end else if (int_ack_i) begin
                    state_next = SERVICE;
                    rr_next    = wrap_idx(winner_reg, 1);
                end
            end
            SERVICE: begin
                if (complete) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            enable_reg    <= '0;
            mode_reg      <= '0;
            src_d_reg     <= '0;
            edge_pend_reg <= '0;
            rr_reg        <= '0;
            winner_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            src_d_reg     <= src_i;
            edge_pend_reg <= edge_pend_next;
            rr_reg        <= rr_next;
            winner_reg    <= winner_next;
            if (wr_enable) begin
                enable_reg <= data_i[NUM_SRC-1:0];
            end
            if (wr_mode) begin
                mode_reg <= data_i[NUM_SRC-1:0];
            end
        end
    end

    assign int_flag_o = (state_reg == ASSERT) ? 8'h01 : 8'h00;
    assign irq_id_o   = ((state_reg == ASSERT) || (state_reg == SERVICE)) ? win_id : '0;

    always_comb begin
        data_o = '0;
        case (addr_i[3:2])
            REG_ENABLE:  data_o[NUM_SRC-1:0] = enable_reg;
            REG_MODE:    data_o[NUM_SRC-1:0] = mode_reg;
            REG_PENDING: data_o[NUM_SRC-1:0] = pending;
            REG_CLAIM:   data_o[ID_W-1:0]    = irq_id_o;
            default:     data_o              = '0;
        endcase
    end

    assign unused_bits = &{1'b0, addr_i[31:4], addr_i[1:0], data_i[31:NUM_SRC]};

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: register vector table, directed corner sequences,
// then randomized traffic compared against a behavioural model.
module tb_int_arbiter;

    localparam int N   = 8;
    localparam int IDW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            ack;
    logic [7:0]      flag;
    logic [IDW-1:0]  irq_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_arbiter #(.NUM_SRC(N), .ID_W(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_i      (src),
        .we_i       (we),
        .addr_i     (addr),
        .data_i     (wdata),
        .data_o     (rdata),
        .int_ack_i  (ack),
        .int_flag_o (flag),
        .irq_id_o   (irq_id)
    );

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[7];

    // Behavioural model state: plain arrays and an integer phase (0 idle, 1 asserting, 2 in service).
    bit m_en[N];
    bit m_md[N];
    bit m_pe[N];
    bit m_prev[N];
    int m_rr;
    int m_phase;
    int m_win;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        $display("write addr=0x%0h data=0x%0h flag=%0h id=%0d", a, d, flag, irq_id);
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
        addr = '0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        $display("ack flag=%0h id=%0d", flag, irq_id);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        src   = '0;
        we    = 1'b0;
        ack   = 1'b0;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            case (a[3:2])
                2'd0: v[i] = m_en[i];
                2'd1: v[i] = m_md[i];
                2'd2: v[i] = m_md[i] ? m_pe[i] : m_prev[i];
                default: ;
            endcase
        end
        if (a[3:2] == 2'd3) begin
            v = (m_phase != 0) ? 32'(m_win + 1) : 32'd0;
        end
        return v;
    endfunction

    task automatic m_step(input logic [N-1:0] s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic k);
        bit elig[N];
        int nphase, nwin, nrr, clr_idx, i;
        bit hit;
        for (int j = 0; j < N; j++) begin
            elig[j] = (m_md[j] ? m_pe[j] : m_prev[j]) && m_en[j] && !(m_phase == 2 && j == m_win);
        end
        nphase  = m_phase;
        nwin    = m_win;
        nrr     = m_rr;
        clr_idx = -1;
        hit     = 0;
        if (m_phase == 0) begin
            for (int off = 0; off < N; off++) begin
                i = (m_rr + off) % N;
                if (!hit && elig[i]) begin
                    hit    = 1;
                    nphase = 1;
                    nwin   = i;
                end
            end
        end else if (m_phase == 1) begin
            if (!m_en[m_win] || (!m_md[m_win] && !m_prev[m_win])) begin
                nphase = 0;
            end else if (k) begin
                nphase  = 2;
                clr_idx = m_win;
                nrr     = (m_win + 1) % N;
            end
        end else begin
            if (w && a[3:2] == 2'd3 && int'(d[IDW-1:0]) == m_win + 1) nphase = 0;
        end
        for (int j = 0; j < N; j++) begin
            m_pe[j] = m_md[j] && ((s[j] && !m_prev[j]) || (m_pe[j] && j != clr_idx));
        end
        for (int j = 0; j < N; j++) begin
            if (w && a[3:2] == 2'd0) m_en[j] = d[j];
            if (w && a[3:2] == 2'd1) m_md[j] = d[j];
            m_prev[j] = s[j];
        end
        m_phase = nphase;
        m_win   = nwin;
        m_rr    = nrr;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int exp_ids[4];
        logic [N-1:0] s;
        logic [31:0]  a, d;
        logic         w, k;

        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_00A5, 32'h0, 32'hA5, "vec_enable"};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'hFFFF_FF3C, 32'h4, 32'h3C, "vec_mode_upper"};
        vecs[2] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 32'h8, 32'h0,  "vec_pending_ro"};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,         32'hC, 32'h0,  "vec_claim_idle"};
        vecs[4] = '{1'b1, 32'h0000_0010, 32'h0000_0011, 32'h0, 32'h11, "vec_alias_enable"};
        vecs[5] = '{1'b1, 32'hF000_0007, 32'h0000_0000, 32'h4, 32'h0,  "vec_alias_mode"};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0, 32'h0,  "vec_enable_clr"};

        // Reset state
        rst = 1'b1; src = '0; we = 1'b0; ack = 1'b0; addr = '0; wdata = '0;
        tick();
        check("rst_flag", flag, 32'h0);
        check("rst_id", irq_id, 32'h0);
        check_reg("rst_enable", 32'h0, 32'h0);
        check_reg("rst_mode", 32'h4, 32'h0);
        check_reg("rst_pending", 32'h8, 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
            check_reg(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // Single edge on source 0
        do_reset();
        bus_write(32'h0, 32'h1);
        bus_write(32'h4, 32'h1);
        src = 8'h01; tick(); src = 8'h00;
        check("se_flag_early", flag, 32'h0);
        check_reg("se_pend_set", 32'h8, 32'h1);
        tick();
        check("se_flag", flag, 32'h1);
        check("se_id", irq_id, 32'h1);
        pulse_ack();
        check("se_flag_after_ack", flag, 32'h0);
        check_reg("se_pend_cleared", 32'h8, 32'h0);
        check_reg("se_claim_read", 32'hC, 32'h1);
        bus_write(32'hC, 32'h1);
        check("se_done_id", irq_id, 32'h0);
        check("se_done_flag", flag, 32'h0);

        // Round-robin over level lines 1, 3, 5
        do_reset();
        bus_write(32'h0, 32'hFF);
        src = 8'h2A; tick(); tick();
        exp_ids = '{2, 4, 6, 2};
        for (int j = 0; j < 4; j++) begin
            check($sformatf("rr_flag_%0d", j), flag, 32'h1);
            check($sformatf("rr_id_%0d", j), irq_id, 32'(exp_ids[j]));
            pulse_ack();
            check($sformatf("rr_serv_flag_%0d", j), flag, 32'h0);
            bus_write(32'hC, 32'(exp_ids[j]));
            check($sformatf("rr_idle_id_%0d", j), irq_id, 32'h0);
            tick();
        end

        // Masking, enable drop and level drop on source 2
        do_reset();
        src = 8'h04; tick(); tick(); tick();
        check("mask_no_assert", flag, 32'h0);
        check_reg("mask_pending", 32'h8, 32'h04);
        bus_write(32'h0, 32'h04);
        check("mask_write_edge", flag, 32'h0);
        tick();
        check("mask_assert", flag, 32'h1);
        check("mask_id", irq_id, 32'h3);
        bus_write(32'h0, 32'h0);
        check("mask_hold", flag, 32'h1);
        tick();
        check("mask_drop_flag", flag, 32'h0);
        check("mask_drop_id", irq_id, 32'h0);
        bus_write(32'h0, 32'h04);
        tick();
        check("lvl_assert", flag, 32'h1);
        src = 8'h00; tick();
        check("lvl_hold", flag, 32'h1);
        tick();
        check("lvl_drop", flag, 32'h0);

        // Re-edge on source 4 while it is in service
        do_reset();
        bus_write(32'h0, 32'h10);
        bus_write(32'h4, 32'h10);
        src = 8'h10; tick(); src = 8'h00; tick();
        check("re_id", irq_id, 32'h5);
        pulse_ack();
        check_reg("re_pend_clr", 32'h8, 32'h0);
        src = 8'h10; tick(); src = 8'h00;
        check_reg("re_pend_again", 32'h8, 32'h10);
        tick(); tick();
        check("re_no_assert", flag, 32'h0);
        check("re_in_service", irq_id, 32'h5);
        bus_write(32'hC, 32'h5);
        check("re_complete", irq_id, 32'h0);
        tick();
        check("re_reassert_flag", flag, 32'h1);
        check("re_reassert_id", irq_id, 32'h5);

        // Wrong completion value
        do_reset();
        bus_write(32'h0, 32'h04);
        src = 8'h04; tick(); tick();
        check("wc_id", irq_id, 32'h3);
        pulse_ack();
        bus_write(32'hC, 32'h7);
        check("wc_still_id", irq_id, 32'h3);
        check_reg("wc_claim_read", 32'hC, 32'h3);
        check("wc_flag", flag, 32'h0);

        // Asynchronous reset in the middle of ASSERT
        do_reset();
        bus_write(32'h0, 32'h01);
        src = 8'h01; tick(); tick();
        check("ar_pre_flag", flag, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_flag", flag, 32'h0);
        check("ar_id", irq_id, 32'h0);
        check_reg("ar_enable", 32'h0, 32'h0);
        check_reg("ar_mode", 32'h4, 32'h0);
        check_reg("ar_pending", 32'h8, 32'h0);
        check_reg("ar_claim", 32'hC, 32'h0);
        src = 8'h00;
        tick();
        rst = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int j = 0; j < N; j++) begin
            m_en[j] = 0; m_md[j] = 0; m_pe[j] = 0; m_prev[j] = 0;
        end
        m_rr = 0; m_phase = 0; m_win = 0;
        s = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(7) == 0) s[j] = ~s[j];
            end
            k = ($urandom_range(2) == 0);
            w = ($urandom_range(5) == 0);
            a = $urandom;
            a[3:2] = 2'($urandom_range(3));
            d = $urandom;
            if (a[3:2] == 2'd3 && m_phase == 2 && $urandom_range(1) == 0) d[IDW-1:0] = IDW'(m_win + 1);
            src = s; ack = k; we = w; addr = a; wdata = d;
            #1;
            check($sformatf("rand_rdata_%0d", cyc), rdata, m_read(a));
            @(posedge clk);
            m_step(s, w, a, d, k);
            #1;
            check($sformatf("rand_flag_%0d", cyc), flag, (m_phase == 1) ? 32'h1 : 32'h0);
            check($sformatf("rand_id_%0d", cyc), irq_id, (m_phase != 0) ? 32'(m_win + 1) : 32'h0);
            if (w) $display("rand write addr=0x%0h data=0x%0h flag=%0h id=%0d", a, d, flag, irq_id);
        end
        we = 1'b0; ack = 1'b0; src = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
